pc_seq: RTL
===========

# pc_seq

Fetch-side program-counter sequencer for the single-issue core. It owns the architectural PC and issues one instruction-memory request at a time with a req/gnt/rvalid handshake. It hands each fetched word to decode over a valid/ready interface and applies branch and trap redirects, discarding any stale in-flight response. It sits between instruction memory, the decode stage, and the execute-stage branch-target adder.

## Interface
- WORDSIZE, 32, datapath and address width
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request; held high until granted
- imem_addr  out  WORDSIZE  fetch address, equals pc while imem_req=1
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  WORDSIZE  fetched instruction word
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts instruction
- if_pc  out  WORDSIZE  address of the instruction on if_inst
- if_inst  out  WORDSIZE  buffered instruction word
- br_taken  in  1  single-cycle branch/jump redirect strobe
- br_target  in  WORDSIZE  redirect address from the branch-target adder
- trap  in  1  single-cycle trap redirect strobe; has priority over br_taken
- trap_vec  in  WORDSIZE  trap handler address
- fetch_misalign  out  1  one-cycle pulse: redirect target had bits[1:0]≠0

## Operation
- States: FETCH, WAIT, HOLD, DISCARD. Reset state is FETCH.
- FETCH: imem_req=1 and imem_addr=pc. On imem_gnt, go to WAIT.
- WAIT: on imem_rvalid, latch if_inst=imem_rdata and if_pc=pc, set pc<=pc+4, then go to HOLD.
- HOLD: if_valid=1. On if_ready, clear if_valid and go to FETCH. There is no prefetch; peak throughput is 1 instruction per 3 cycles with 1-cycle memory.
- Redirect, when trap or br_taken is high in any state:
  - Load pc<=target with bits[1:0] forced to 0. If the original bits[1:0]≠0, pulse fetch_misalign.
  - Clear if_valid in the same edge; a buffered instruction is dropped even if if_ready=1 that cycle.
  - Next state is DISCARD if a granted request is still unanswered. This covers FETCH with imem_gnt=1 in the same cycle, and WAIT without imem_rvalid.
  - Otherwise the next state is FETCH. This covers WAIT with imem_rvalid in the same cycle: the response is dropped.
- DISCARD: imem_req=0. On imem_rvalid, drop the data and go to FETCH. A redirect in DISCARD updates pc and stays in DISCARD.
- imem_rvalid outside WAIT/DISCARD is ignored (memory shares reset, so no responses survive reset).
- Arithmetic: pc+4 is modulo 2^WORDSIZE; 32'hFFFF_FFFC increments to 32'h0000_0000 without a flag.
- Reset mid-operation:
  - Any state returns to FETCH with pc=RESET_ADDR.
  - The outstanding request is abandoned.

## Timing
- Reset values: pc=RESET_ADDR, imem_req=0, imem_addr=RESET_ADDR, if_valid=0, if_pc=0, if_inst=0, fetch_misalign=0.
- imem_req and if_valid are decoded from registered state only, with no input-to-output combinational paths. imem_req rises the first cycle after reset deasserts.
- imem_rvalid at edge N gives if_valid=1 during cycle N+1.
- Redirect at edge N: the new imem_addr is presented in cycle N+1 (FETCH case), or in the cycle after the stale rvalid is consumed (DISCARD case).
- imem_addr is stable while imem_req=1 and imem_gnt=0.

## Test plan
- Reset, 1-cycle memory, if_ready=1:
  - imem_addr sequence is 0x0, 0x4, 0x8.
  - if_pc/if_inst pairs match memory.
  - if_valid rises 3 cycles apart.
- Backpressure: if_ready=0 for 5 cycles in HOLD.
  - if_valid, if_pc and if_inst stay stable.
  - No imem_req is issued until if_ready=1.
- Branch while in WAIT, with br_target=0x100 and rvalid 2 cycles later:
  - The state passes through DISCARD and the stale word never appears on if_valid.
  - The next imem_addr is 0x100.
- trap and br_taken in the same cycle (trap_vec=0x80, br_target=0x200):
  - pc=0x80.
  - The rvalid arriving in the same cycle is dropped.
- br_target=0x103:
  - fetch_misalign pulses 1 cycle.
  - The next fetch is from 0x100.
- Wrap and reset:
  - Fetch from 0xFFFFFFFC; the next fetch is from 0x0.
  - Assert reset in WAIT: the next imem_addr is RESET_ADDR and if_valid stays 0.

Source files
------------

// File: rtl/pc_seq.sv
// pc_seq: fetch-side PC sequencer with one outstanding imem request, decode handoff and branch/trap redirect
//   CLK, reset            clock, synchronous active-high reset
//   imem_req/addr/gnt     fetch request channel (addr = pc while req is high)
//   imem_rvalid/rdata     fetch response channel
//   if_valid/ready        decode handoff; if_pc/if_inst hold the buffered instruction
//   br_taken/br_target    branch redirect strobe and target
//   trap/trap_vec         trap redirect strobe and vector (wins over br_taken)
//   fetch_misalign        one-cycle pulse when a redirect target was not word aligned
module pc_seq #(
    parameter int                  WORDSIZE   = 32,
    parameter logic [WORDSIZE-1:0] RESET_ADDR = '0
) (
    input  logic                CLK,
    input  logic                reset,
    output logic                imem_req,
    output logic [WORDSIZE-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [WORDSIZE-1:0] imem_rdata,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [WORDSIZE-1:0] if_pc,
    output logic [WORDSIZE-1:0] if_inst,
    input  logic                br_taken,
    input  logic [WORDSIZE-1:0] br_target,
    input  logic                trap,
    input  logic [WORDSIZE-1:0] trap_vec,
    output logic                fetch_misalign
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DISCARD} state_t;
    state_t state, state_nxt;
    logic                run, redir, pending, accept;
    logic [WORDSIZE-1:0] pc, tgt;
    // run keeps imem_req low while reset is applied and for the reset edge itself
    assign imem_req  = run && state == FETCH;
    assign imem_addr = pc;
    assign if_valid  = state == HOLD;
    always_comb begin
        redir   = trap | br_taken;
        tgt     = trap ? trap_vec : br_target;
        accept  = state == WAIT && imem_rvalid;
        // a granted request whose response has not yet arrived must be drained in DISCARD
        pending = (state == FETCH && imem_req && imem_gnt) ||
                  ((state == WAIT || state == DISCARD) && !imem_rvalid);
        state_nxt = redir            ? (pending ? DISCARD : FETCH)
                  : state == FETCH   ? (imem_req && imem_gnt ? WAIT : FETCH)
                  : state == WAIT    ? (imem_rvalid ? HOLD : WAIT)
                  : state == HOLD    ? (if_ready ? FETCH : HOLD)
                  :                    (imem_rvalid ? FETCH : DISCARD);
    end
    always_ff @(posedge CLK) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_nxt;
    end
    always_ff @(posedge CLK) begin
        if (reset) begin
            run            <= 1'b0;
            pc             <= RESET_ADDR;
            if_pc          <= '0;
            if_inst        <= '0;
            fetch_misalign <= 1'b0;
        end else begin
            run            <= 1'b1;
            fetch_misalign <= redir && tgt[1:0] != 2'b00;
            pc             <= redir ? {tgt[WORDSIZE-1:2], 2'b00} : accept ? pc + WORDSIZE'(4) : pc;
            if (accept && !redir) begin
                if_pc   <= pc;
                if_inst <= imem_rdata;
            end
        end
    end
endmodule
